// File: rtl/serial_adder_if.sv
// ============================================================================
// serial_adder_if : start/busy/done handshake and operand/result bundle.
// Optional SERIAL_ADDER_SUB_EN adds the sub select.  Rev 1.0
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : multi-cycle adder, DIGIT bits per clock with registered carry.
// Optional feature macro: SERIAL_ADDER_SUB_EN (subtract select).  Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    // Illegal geometry elaborates a module that does not exist.
    if ((WIDTH % DIGIT) != 0 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_geometry
        serial_adder_width_must_be_multiple_of_digit u_bad_geometry ();
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_part;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [WIDTH-1:0]       w_b_in;
    logic                   w_c_in;
    logic [DIGIT:0]         w_step;
    logic                   w_cmsb;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_next_part;
    logic                   w_last;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; cin is ignored in that mode.
    assign w_b_in = bus.sub ? ~bus.b : bus.b;
    assign w_c_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign w_b_in = bus.b;
    assign w_c_in = bus.cin;
`endif

    assign w_step = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
    // Carry into the top bit of this digit; meaningful on the final step only.
    assign w_cmsb      = w_step[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_cat       = {w_step[DIGIT-1:0], r_part} >> DIGIT;
    assign w_next_part = w_cat[WIDTH-1:0];
    assign w_last      = (r_cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_part  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_part  <= w_next_part;
                    r_carry <= w_step[DIGIT];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_sum   <= w_next_part;
                        r_cout  <= w_step[DIGIT];
                        r_ovf   <= w_cmsb ^ w_step[DIGIT];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : directed, scoreboarded bench for serial_adder
// (8-bit/1-bit-digit and 16-bit/4-bit-digit instances).  Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done8 = 0;
    int   n_done16 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic on w-bit operands (w <= 16).
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        logic [16:0] mask;
        logic [16:0] aa;
        logic [16:0] bb;
        logic [16:0] full;
        exp_t        e;
        mask = (17'd1 << w) - 17'd1;
        aa   = {1'b0, a} & mask;
        bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
        full = aa + bb + {16'd0, (sub ? 1'b1 : cin)};
        e.sum  = 16'(full & mask);
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (if8.done) begin
            exp_t e;
            n_done8++;
            if (q8.size() == 0) check("sb8_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                check("sb8_sum",  {24'd0, if8.sum}, {16'd0, e.sum});
                check("sb8_cout", {31'd0, if8.cout}, {31'd0, e.cout});
                check("sb8_ovf",  {31'd0, if8.ovf},  {31'd0, e.ovf});
            end
        end
        if (if16.done) begin
            exp_t e;
            n_done16++;
            if (q16.size() == 0) check("sb16_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q16.pop_front();
                check("sb16_sum",  {16'd0, if16.sum}, {16'd0, e.sum});
                check("sb16_cout", {31'd0, if16.cout}, {31'd0, e.cout});
                check("sb16_ovf",  {31'd0, if16.ovf},  {31'd0, e.ovf});
            end
        end
    end

    // Called at a negedge; returns at the next negedge with start released.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub);
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if8.sub   = sub;
`endif
        q8.push_back(model(8, {8'd0, a}, {8'd0, b}, cin, sub));
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic wait_done8(input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (if8.done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("timeout8", 32'd1, 32'd0);
    endtask

    initial begin
        int   lat;
        int   d0;
        logic held_ok;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if8.sub = 1'b0; if16.sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_outputs", {if8.busy, if8.done, if8.cout, if8.ovf, 20'd0, if8.sum}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Signed overflow add, with latency and single-cycle done
        start8(8'h5A, 8'h3C, 1'b0, 1'b0);
        check("busy_after_start", {31'd0, if8.busy}, 32'd1);
        wait_done8(20, lat);
        check("latency_8", lat, 8);
        check("busy_in_done", {31'd0, if8.busy}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, if8.done}, 32'd0);
        check("sum_held_idle", {24'd0, if8.sum}, 32'h96);

        // Carry wrap-around cases
        start8(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done8(20, lat);
        @(negedge clk);
        start8(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done8(20, lat);
        @(negedge clk);

        // Start while busy is ignored
        d0 = n_done8;
        start8(8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01;
        @(negedge clk);
        if8.start = 1'b0;
        wait_done8(20, lat);
        check("latency_ignored_start", lat, 6);
        repeat (4) @(negedge clk);
        check("single_done", n_done8 - d0, 1);
        check("idle_after_ignore", {31'd0, if8.busy}, 32'd0);

        // Reset mid-operation aborts
        d0 = n_done8;
        start8(8'h33, 8'h44, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", {if8.busy, if8.done, if8.cout, if8.ovf, 20'd0, if8.sum}, 32'd0);
        q8.delete();
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done", n_done8 - d0, 0);

        // Back-to-back: start on the done cycle, old sum held until new done
        start8(8'h12, 8'h34, 1'b0, 1'b0);
        wait_done8(20, lat);
        start8(8'h70, 8'h70, 1'b0, 1'b0);
        held_ok = 1'b1;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (if8.sum !== 8'h46 || if8.done !== 1'b0 || if8.busy !== 1'b1) held_ok = 1'b0;
        end
        check("held_during_b2b", {31'd0, held_ok}, 32'd1);
        @(negedge clk);
        check("b2b_done", {31'd0, if8.done}, 32'd1);
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        start8(8'h10, 8'h20, 1'b0, 1'b1);
        wait_done8(20, lat);
        @(negedge clk);
        start8(8'h80, 8'h01, 1'b1, 1'b1);
        wait_done8(20, lat);
        @(negedge clk);
        start8(8'h05, 8'h03, 1'b1, 1'b0);
        wait_done8(20, lat);
        @(negedge clk);
`endif

        // 16-bit, 4 bits per clock
        if16.start = 1'b1; if16.a = 16'h1234; if16.b = 16'hEDCC; if16.cin = 1'b0;
        q16.push_back(model(16, 16'h1234, 16'hEDCC, 1'b0, 1'b0));
        @(negedge clk);
        if16.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (if16.done) begin lat = k; break; end
        end
        check("latency_16", lat, 4);
        @(negedge clk);
        if16.start = 1'b1; if16.a = 16'h7FFF; if16.b = 16'h0001;
        q16.push_back(model(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0));
        @(negedge clk);
        if16.start = 1'b0;
        repeat (8) @(negedge clk);

        check("q8_drained",  q8.size(), 0);
        check("q16_drained", q16.size(), 0);
        check("done16_count", n_done16, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
